// File: rtl/kernel_pingpong_ctrl_if.sv
// AXI-Stream kernel-word channel feeding the ping-pong kernel buffer controller.
// A beat transfers on any rising clk edge where tvalid and tready are both high.
interface kernel_pingpong_ctrl_if #(
    parameter int DATA_W = 72
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/kernel_pingpong_ctrl.sv
// Double-buffered kernel BRAM controller: one bank is filled from AXI-Stream while
// the MAC array reads channel addresses from the other bank.
module kernel_pingpong_ctrl #(
    parameter int DATA_W = 72,
    parameter int MAX_CH = 256,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  flush,
    input  logic [CNT_W:0]        channel_size,
    input  logic                  load_req,
    input  logic                  next_ch,
    kernel_pingpong_ctrl_if.slave s_axis,
    output logic                  wea,
    output logic [CNT_W:0]        addra,
    output logic [DATA_W-1:0]     dina,
    output logic                  enb,
    output logic [CNT_W:0]        addrb,
    output logic                  kernel_ready,
    output logic                  load_done,
    output logic                  last_channel,
    output logic                  tlast_err,
    output logic [1:0]            w_state_dbg
);
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LOAD = 2'd1,
        W_DONE = 2'd2
    } w_state_t;

    w_state_t         w_state;
    logic [1:0]       full;
    logic [CNT_W:0]   len_q [0:1];
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    logic             beat;
    logic             wr_final;
    logic             rd_step;
    logic             rd_release;
    logic             size_ok;
    logic [CNT_W:0]   wr_len_m1;
    logic [CNT_W:0]   rd_len_m1;

    assign wr_len_m1  = len_q[wr_bank] - 1'b1;
    assign rd_len_m1  = len_q[rd_bank] - 1'b1;
    assign size_ok    = (channel_size != '0) && (channel_size <= (CNT_W+1)'(MAX_CH));

    // A load only ever targets an empty bank, so being in W_LOAD is sufficient for ready.
    assign s_axis.tready = (w_state == W_LOAD);
    assign beat          = s_axis.tready & s_axis.tvalid;
    assign wr_final      = ({1'b0, wr_cnt} == wr_len_m1);

    assign wea   = beat;
    assign addra = {wr_bank, wr_cnt};
    assign dina  = s_axis.tdata;

    assign kernel_ready = full[rd_bank];
    assign enb          = kernel_ready;
    assign addrb        = {rd_bank, rd_cnt};
    assign rd_step      = next_ch & kernel_ready;
    assign rd_release   = rd_step & ({1'b0, rd_cnt} == rd_len_m1);
    assign last_channel = rd_release;

    assign w_state_dbg = w_state;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            w_state   <= W_IDLE;
            full      <= 2'b00;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            load_done <= 1'b0;
            tlast_err <= 1'b0;
        end else if (flush) begin
            w_state   <= W_IDLE;
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            load_done <= 1'b0;
            tlast_err <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (load_req && !full[wr_bank] && size_ok) begin
                        len_q[wr_bank] <= channel_size;
                        wr_cnt         <= '0;
                        w_state        <= W_LOAD;
                    end
                end
                W_LOAD: begin
                    if (beat) begin
                        // The beat count terminates the set; tlast is only cross-checked.
                        if (s_axis.tlast != wr_final) tlast_err <= 1'b1;
                        if (wr_final) begin
                            full[wr_bank] <= 1'b1;
                            wr_bank       <= ~wr_bank;
                            wr_cnt        <= '0;
                            load_done     <= 1'b1;
                            w_state       <= W_DONE;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                W_DONE:  w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase

            // Write completion and read release never hit the same bank.
            if (rd_release) begin
                rd_cnt        <= '0;
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end else if (rd_step) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_kernel_pingpong_ctrl.sv
// Self-checking bench for kernel_pingpong_ctrl: directed scenarios plus a randomized
// run checked cycle by cycle against a bank-bookkeeping reference model.
module tb_kernel_pingpong_ctrl;
  localparam int DATA_W = 72;
  localparam int MAX_CH = 256;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic flush = 1'b0;
  logic load_req = 1'b0;
  logic next_ch = 1'b0;
  logic [CNT_W:0] channel_size = '0;

  logic wea, enb, kernel_ready, load_done, last_channel, tlast_err;
  logic [CNT_W:0] addra, addrb;
  logic [DATA_W-1:0] dina;
  logic [1:0] w_state_dbg;

  kernel_pingpong_ctrl_if #(.DATA_W(DATA_W)) s_axis ();

  kernel_pingpong_ctrl #(.DATA_W(DATA_W), .MAX_CH(MAX_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .Reset(Reset), .flush(flush), .channel_size(channel_size),
    .load_req(load_req), .next_ch(next_ch), .s_axis(s_axis),
    .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
    .kernel_ready(kernel_ready), .load_done(load_done), .last_channel(last_channel),
    .tlast_err(tlast_err), .w_state_dbg(w_state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which banks hold a set, their lengths, and where each side is.
  bit m_full [2];
  int m_len [2];
  int m_wr_bank, m_rd_bank, m_wr_cnt, m_rd_cnt;
  bit m_loading, m_done, m_err;

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wr_bank = 0; m_rd_bank = 0; m_wr_cnt = 0; m_rd_cnt = 0;
    m_loading = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit was_done;
    bit rel;
    int rb;
    if (flush) begin
      model_reset();
      return;
    end
    rb = m_rd_bank;
    rel = next_ch && m_full[rb] && (m_rd_cnt == m_len[rb] - 1);
    if (next_ch && m_full[rb] && !rel) m_rd_cnt++;
    was_done = m_done;
    m_done = 0;
    if (m_loading) begin
      if (s_axis.tvalid) begin
        if (s_axis.tlast != (m_wr_cnt == m_len[m_wr_bank] - 1)) m_err = 1;
        if (m_wr_cnt == m_len[m_wr_bank] - 1) begin
          m_full[m_wr_bank] = 1;
          m_wr_bank = 1 - m_wr_bank;
          m_wr_cnt = 0;
          m_loading = 0;
          m_done = 1;
        end else begin
          m_wr_cnt++;
        end
      end
    end else if (!was_done && load_req && !m_full[m_wr_bank] &&
                 channel_size != 0 && int'(channel_size) <= MAX_CH) begin
      m_len[m_wr_bank] = int'(channel_size);
      m_wr_cnt = 0;
      m_loading = 1;
    end
    if (rel) begin
      m_full[rb] = 0;
      m_rd_cnt = 0;
      m_rd_bank = 1 - rb;
    end
  endtask

  // Driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; load_req = 0; next_ch = 0;
    s_axis.tvalid = 0; s_axis.tlast = 0;
  endtask

  task automatic do_load(input int c);
    channel_size = (CNT_W+1)'(c);
    load_req = 1;
    tick();
    load_req = 0;
    for (int i = 0; i < c; i++) begin
      s_axis.tvalid = 1;
      s_axis.tdata = DATA_W'({$urandom(), $urandom(), $urandom()});
      s_axis.tlast = (i == c - 1);
      tick();
    end
    s_axis.tvalid = 0;
    s_axis.tlast = 0;
    tick();
  endtask

  task automatic do_flush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    load_req = 1; s_axis.tvalid = 1; next_ch = 1; channel_size = 4;
    #1;
    checks++; if (wea !== 1'b0) begin errors++; $display("FAIL reset_wea got %0b want 0", wea); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %0b want 0", s_axis.tready); end
    checks++; if (addra !== 9'd0) begin errors++; $display("FAIL reset_addra got %0d want 0", addra); end
    checks++; if (addrb !== 9'd0) begin errors++; $display("FAIL reset_addrb got %0d want 0", addrb); end
    checks++; if (enb !== 1'b0) begin errors++; $display("FAIL reset_enb got %0b want 0", enb); end
    checks++; if (kernel_ready !== 1'b0) begin errors++; $display("FAIL reset_kready got %0b want 0", kernel_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %0b want 0", load_done); end
    checks++; if (last_channel !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", last_channel); end
    checks++; if (tlast_err !== 1'b0) begin errors++; $display("FAIL reset_tlast_err got %0b want 0", tlast_err); end
    idle_inputs();
    Reset = 1;
    tick();
  endtask

  task automatic test_basic_load();
    channel_size = 4;
    load_req = 1;
    tick();
    load_req = 0;
    for (int i = 0; i < 4; i++) begin
      s_axis.tvalid = 1;
      s_axis.tdata = DATA_W'({$urandom(), $urandom(), $urandom()});
      s_axis.tlast = (i == 3);
      #1;
      checks++; if (wea !== 1'b1 || s_axis.tready !== 1'b1) begin errors++; $display("FAIL basic_wea beat %0d got wea=%0b tready=%0b want 1", i, wea, s_axis.tready); end
      checks++; if (addra !== 9'(i)) begin errors++; $display("FAIL basic_addra beat %0d got %0d want %0d", i, addra, i); end
      checks++; if (dina !== s_axis.tdata) begin errors++; $display("FAIL basic_dina beat %0d got %h want %h", i, dina, s_axis.tdata); end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_load_done got %0b want 1", load_done); end
    checks++; if (kernel_ready !== 1'b1 || enb !== 1'b1) begin errors++; $display("FAIL basic_kready got %0b enb %0b want 1", kernel_ready, enb); end
    checks++; if (tlast_err !== 1'b0) begin errors++; $display("FAIL basic_tlast_err got %0b want 0", tlast_err); end
    tick();
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", load_done); end
  endtask

  task automatic test_read();
    for (int i = 0; i < 4; i++) begin
      next_ch = 1;
      #1;
      checks++; if (addrb !== 9'(i)) begin errors++; $display("FAIL read_addrb ch %0d got %0d want %0d", i, addrb, i); end
      checks++; if (last_channel !== (i == 3)) begin errors++; $display("FAIL read_last ch %0d got %0b want %0b", i, last_channel, (i == 3)); end
      tick();
    end
    next_ch = 0;
    #1;
    checks++; if (kernel_ready !== 1'b0 || enb !== 1'b0) begin errors++; $display("FAIL read_kready_drop got %0b want 0", kernel_ready); end
    checks++; if (addrb !== 9'd256) begin errors++; $display("FAIL read_rd_bank got addrb %0d want 256", addrb); end
  endtask

  task automatic test_pingpong();
    do_flush();
    do_load(3);
    next_ch = 1; load_req = 1; channel_size = 5;
    #1;
    checks++; if (addrb !== 9'd0) begin errors++; $display("FAIL pp_addrb0 got %0d want 0", addrb); end
    tick();
    load_req = 0; channel_size = 2;
    for (int i = 0; i < 5; i++) begin
      s_axis.tvalid = 1; s_axis.tlast = (i == 4); next_ch = (i == 0);
      s_axis.tdata = DATA_W'({$urandom(), $urandom(), $urandom()});
      #1;
      checks++; if (addra !== 9'(256 + i) || wea !== 1'b1) begin errors++; $display("FAIL pp_addra beat %0d got %0d wea %0b want %0d", i, addra, wea, 256 + i); end
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (load_done !== 1'b1 || addrb !== 9'd2 || kernel_ready !== 1'b1) begin errors++; $display("FAIL pp_overlap got done %0b addrb %0d kready %0b want 1 2 1", load_done, addrb, kernel_ready); end
    next_ch = 1;
    #1;
    checks++; if (last_channel !== 1'b1) begin errors++; $display("FAIL pp_last0 got %0b want 1", last_channel); end
    tick();
    next_ch = 0;
    #1;
    checks++; if (addrb !== 9'd256 || kernel_ready !== 1'b1) begin errors++; $display("FAIL pp_switch got addrb %0d kready %0b want 256 1", addrb, kernel_ready); end
    for (int i = 0; i < 5; i++) begin
      next_ch = 1;
      #1;
      checks++; if (last_channel !== (i == 4) || addrb !== 9'(256 + i)) begin errors++; $display("FAIL pp_bank1 ch %0d got last %0b addrb %0d want %0b %0d", i, last_channel, addrb, (i == 4), 256 + i); end
      tick();
    end
    next_ch = 0;
  endtask

  task automatic test_both_full();
    do_flush();
    do_load(2);
    do_load(2);
    load_req = 1; channel_size = 3; s_axis.tvalid = 1; s_axis.tlast = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (s_axis.tready !== 1'b0 || wea !== 1'b0) begin errors++; $display("FAIL full_hold cyc %0d got tready %0b wea %0b want 0 0", i, s_axis.tready, wea); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      next_ch = 1;
      #1;
      checks++; if (last_channel !== (i == 1) || s_axis.tready !== 1'b0) begin errors++; $display("FAIL full_release ch %0d got last %0b tready %0b want %0b 0", i, last_channel, s_axis.tready, (i == 1)); end
      tick();
    end
    next_ch = 0;
    #1;
    checks++; if (s_axis.tready !== 1'b0 || kernel_ready !== 1'b1) begin errors++; $display("FAIL full_accept got tready %0b kready %0b want 0 1", s_axis.tready, kernel_ready); end
    tick();
    load_req = 0;
    for (int i = 0; i < 3; i++) begin
      s_axis.tlast = (i == 2);
      #1;
      checks++; if (s_axis.tready !== 1'b1 || wea !== 1'b1 || addra !== 9'(i)) begin errors++; $display("FAIL full_reload beat %0d got tready %0b wea %0b addra %0d want 1 1 %0d", i, s_axis.tready, wea, addra, i); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_tvalid_gaps();
    int k;
    do_flush();
    channel_size = 3; load_req = 1;
    tick();
    load_req = 0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      s_axis.tvalid = (i % 2 == 0);
      s_axis.tlast = (i == 0) || (i == 4);
      #1;
      checks++; if (wea !== s_axis.tvalid || addra !== 9'(k)) begin errors++; $display("FAIL gap_beat cyc %0d got wea %0b addra %0d want %0b %0d", i, wea, addra, s_axis.tvalid, k); end
      if (i == 1) begin
        checks++; if (tlast_err !== 1'b1) begin errors++; $display("FAIL gap_err_early got %0b want 1", tlast_err); end
      end
      if (s_axis.tvalid) k++;
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (load_done !== 1'b1 || tlast_err !== 1'b1 || kernel_ready !== 1'b1) begin errors++; $display("FAIL gap_done got done %0b err %0b kready %0b want 1 1 1", load_done, tlast_err, kernel_ready); end
    tick();
    do_flush();
    #1;
    checks++; if (tlast_err !== 1'b0 || kernel_ready !== 1'b0) begin errors++; $display("FAIL gap_flush got err %0b kready %0b want 0 0", tlast_err, kernel_ready); end
  endtask

  task automatic test_reset_midload();
    channel_size = 8; load_req = 1;
    tick();
    load_req = 0;
    for (int i = 0; i < 2; i++) begin
      s_axis.tvalid = 1; s_axis.tlast = 0;
      tick();
    end
    #3;
    Reset = 0;
    #1;
    checks++; if (s_axis.tready !== 1'b0 || wea !== 1'b0 || addra !== 9'd0) begin errors++; $display("FAIL rst_mid got tready %0b wea %0b addra %0d want 0 0 0", s_axis.tready, wea, addra); end
    checks++; if (kernel_ready !== 1'b0 || load_done !== 1'b0 || tlast_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got kready %0b done %0b err %0b want 0", kernel_ready, load_done, tlast_err); end
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    Reset = 1;
    do_load(2);
    channel_size = 3; load_req = 1;
    tick();
    load_req = 0; s_axis.tvalid = 1; s_axis.tlast = 1;
    tick();
    s_axis.tvalid = 0; s_axis.tlast = 0;
    do_flush();
    #1;
    checks++; if (kernel_ready !== 1'b0 || s_axis.tready !== 1'b0 || addra !== 9'd0 || addrb !== 9'd0 || tlast_err !== 1'b0) begin errors++; $display("FAIL flush_clear got kready %0b tready %0b addra %0d addrb %0d err %0b want all 0", kernel_ready, s_axis.tready, addra, addrb, tlast_err); end
    channel_size = 1; load_req = 1;
    tick();
    load_req = 0; s_axis.tvalid = 1; s_axis.tlast = 1;
    #1;
    checks++; if (addra !== 9'd0 || wea !== 1'b1) begin errors++; $display("FAIL c1_write got addra %0d wea %0b want 0 1", addra, wea); end
    tick();
    idle_inputs();
    #1;
    checks++; if (load_done !== 1'b1 || kernel_ready !== 1'b1 || tlast_err !== 1'b0) begin errors++; $display("FAIL c1_done got done %0b kready %0b err %0b want 1 1 0", load_done, kernel_ready, tlast_err); end
    tick();
  endtask

  task automatic test_random();
    logic [CNT_W:0] e_addra, e_addrb;
    bit e_kr, e_last, e_wea;
    for (int n = 0; n < 600; n++) begin
      flush = ($urandom_range(0, 59) == 0);
      load_req = ($urandom_range(0, 2) == 0);
      channel_size = (CNT_W+1)'($urandom_range(0, 6));
      next_ch = ($urandom_range(0, 2) == 0);
      s_axis.tvalid = $urandom_range(0, 1);
      s_axis.tlast = ($urandom_range(0, 3) == 0);
      s_axis.tdata = DATA_W'({$urandom(), $urandom(), $urandom()});
      #1;
      e_wea = m_loading && s_axis.tvalid;
      e_addra = (CNT_W+1)'(m_wr_bank * MAX_CH + m_wr_cnt);
      e_addrb = (CNT_W+1)'(m_rd_bank * MAX_CH + m_rd_cnt);
      e_kr = m_full[m_rd_bank];
      e_last = next_ch && e_kr && (m_rd_cnt == m_len[m_rd_bank] - 1);
      checks++; if (s_axis.tready !== m_loading || wea !== e_wea) begin errors++; $display("FAIL rnd_wr cyc %0d got tready %0b wea %0b want %0b %0b", n, s_axis.tready, wea, m_loading, e_wea); end
      checks++; if (addra !== e_addra || dina !== s_axis.tdata) begin errors++; $display("FAIL rnd_addra cyc %0d got %0d want %0d", n, addra, e_addra); end
      checks++; if (kernel_ready !== e_kr || enb !== e_kr) begin errors++; $display("FAIL rnd_kready cyc %0d got %0b enb %0b want %0b", n, kernel_ready, enb, e_kr); end
      checks++; if (addrb !== e_addrb) begin errors++; $display("FAIL rnd_addrb cyc %0d got %0d want %0d", n, addrb, e_addrb); end
      checks++; if (last_channel !== e_last) begin errors++; $display("FAIL rnd_last cyc %0d got %0b want %0b", n, last_channel, e_last); end
      checks++; if (load_done !== m_done || tlast_err !== m_err) begin errors++; $display("FAIL rnd_flags cyc %0d got done %0b err %0b want %0b %0b", n, load_done, tlast_err, m_done, m_err); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    s_axis.tdata = '0;
    idle_inputs();
    model_reset();
    m_len[0] = 0; m_len[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_load();
    test_read();
    test_pingpong();
    test_both_full();
    test_tvalid_gaps();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
